// File: rtl/multi_cycle_adder_if.sv
// Operand/result bundle for multi_cycle_adder.
// The requester drives start and the operands, and the adder returns busy, done and the result.
// The master modport is the requester side, and the slave modport is the adder side.
interface multi_cycle_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/multi_cycle_adder.sv
// Chunked ripple adder/subtractor that adds CHUNK bits per clock, which takes WIDTH/CHUNK RUN cycles.
// Latency: start edge E0, then RUN for N cycles, then a one-cycle done pulse after edge EN.
// Backpressure: none. start is ignored while busy. start is accepted in DONE for back-to-back operation.
module multi_cycle_adder #(
   parameter int WIDTH = 16,   // must be a multiple of CHUNK
   parameter int CHUNK = 4     // 1 <= CHUNK <= WIDTH
) (
   input logic clk,
   input logic rst_n,
   multi_cycle_adder_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;       // already inverted for subtract
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             busy_c;
   logic             done_c;
   logic             capture;
   logic             last;
   int               base;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_cin;

   // Operand acceptance is allowed in IDLE and in DONE, so back-to-back requests lose no cycle.
   assign capture = bus.start && ((state == IDLE) || (state == DONE));
   assign last    = (k == KW'(N - 1));

   // Slice out the current chunk and add it with the running carry.
   always_comb begin
      base      = int'(k) * CHUNK;
      a_chunk   = a_r[base +: CHUNK];
      b_chunk   = b_r[base +: CHUNK];
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      // The carry into a bit equals a ^ b ^ s at that bit. Used only on the top chunk.
      msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            busy_c = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = bus.start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture the operands on accept, then write one chunk per RUN edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k      <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (capture) begin
         k     <= '0;
         a_r   <= bus.a;
         b_r   <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub ? 1'b1 : bus.cin;
      end else if (state == RUN) begin
         sum_r[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
         carry                <= chunk_sum[CHUNK];
         k                    <= k + KW'(1);
         if (last) begin
            cout_r <= chunk_sum[CHUNK];
            ovf_r  <= msb_cin ^ chunk_sum[CHUNK];
         end
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder with three instances at CHUNK = 1, 4 and 16 (WIDTH = 16).
// Expected results are queued when start is driven and popped when done is seen.
// Directed vectors run on CHUNK=4, followed by a random sweep on every instance.
module tb_multi_cycle_adder;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct packed {
      logic         busy;
      logic         done;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   multi_cycle_adder_if #(.WIDTH(W)) bus_c1 ();
   multi_cycle_adder_if #(.WIDTH(W)) bus_c4 ();
   multi_cycle_adder_if #(.WIDTH(W)) bus_c16 ();

   multi_cycle_adder #(.WIDTH(W), .CHUNK(1))  dut_c1  (.clk(clk), .rst_n(rst_n), .bus(bus_c1.slave));
   multi_cycle_adder #(.WIDTH(W), .CHUNK(4))  dut_c4  (.clk(clk), .rst_n(rst_n), .bus(bus_c4.slave));
   multi_cycle_adder #(.WIDTH(W), .CHUNK(16)) dut_c16 (.clk(clk), .rst_n(rst_n), .bus(bus_c16.slave));

   function automatic int lat_of(int idx);
      case (idx)
         0:       return 16;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   task automatic set_in(int idx, logic st, logic sb_i, logic [W-1:0] aa, logic [W-1:0] bb, logic ci);
      case (idx)
         0: begin bus_c1.start = st;  bus_c1.sub = sb_i;  bus_c1.a = aa;  bus_c1.b = bb;  bus_c1.cin = ci;  end
         1: begin bus_c4.start = st;  bus_c4.sub = sb_i;  bus_c4.a = aa;  bus_c4.b = bb;  bus_c4.cin = ci;  end
         default: begin bus_c16.start = st; bus_c16.sub = sb_i; bus_c16.a = aa; bus_c16.b = bb; bus_c16.cin = ci; end
      endcase
   endtask

   function automatic obs_t obs(int idx);
      obs_t o;
      case (idx)
         0:       o = '{bus_c1.busy,  bus_c1.done,  bus_c1.sum,  bus_c1.cout,  bus_c1.ovf};
         1:       o = '{bus_c4.busy,  bus_c4.done,  bus_c4.sum,  bus_c4.cout,  bus_c4.ovf};
         default: o = '{bus_c16.busy, bus_c16.done, bus_c16.sum, bus_c16.cout, bus_c16.ovf};
      endcase
      return o;
   endfunction

   // Reference: full-width add in W+1 bits; signed overflow from operand/result sign bits.
   function automatic exp_t model(logic [W-1:0] aa, logic [W-1:0] bb, logic sb_i, logic ci);
      logic [W-1:0] bx;
      logic [W:0]   full;
      exp_t         e;
      bx     = sb_i ? ~bb : bb;
      full   = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, (sb_i ? 1'b1 : ci)};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (aa[W-1] == bx[W-1]) && (full[W-1] != aa[W-1]);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance until done is seen (sampled 1 time unit after each edge), bounded.
   task automatic wait_done(int idx, output int lat);
      lat = 0;
      while (!obs(idx).done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop_check(int idx, string tag);
      exp_t e;
      obs_t o;
      o = obs(idx);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_sum"},  32'(o.sum),  32'(e.sum));
      chk({tag, "_cout"}, 32'(o.cout), 32'(e.cout));
      chk({tag, "_ovf"},  32'(o.ovf),  32'(e.ovf));
   endtask

   task automatic run_op(int idx, logic [W-1:0] aa, logic [W-1:0] bb, logic sb_i, logic ci,
                         exp_t e, string tag);
      int lat;
      sb.push_back(e);
      set_in(idx, 1'b1, sb_i, aa, bb, ci);
      @(posedge clk); #1;
      set_in(idx, 1'b0, 1'b0, '0, '0, 1'b0);
      chk({tag, "_busy"}, 32'(obs(idx).busy), 32'd1);
      wait_done(idx, lat);
      chk({tag, "_latency"}, 32'(lat), 32'(lat_of(idx)));
      pop_check(idx, tag);
   endtask

   initial begin
      int   lat;
      int   done_seen;
      obs_t o;
      logic [W-1:0] ra, rb;
      logic rs, rc;

      for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, '0, '0, 1'b0);

      // Reset values
      #2;
      o = obs(1);
      chk("rst_busy", 32'(o.busy), 32'd0);
      chk("rst_done", 32'(o.done), 32'd0);
      chk("rst_sum",  32'(o.sum),  32'd0);
      chk("rst_cout", 32'(o.cout), 32'd0);
      chk("rst_ovf",  32'(o.ovf),  32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed arithmetic on CHUNK=4
      run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, "add_carry");
      run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, "add_ovf");
      run_op(1, 16'h1234, 16'h1111, 1'b0, 1'b1, '{16'h2346, 1'b0, 1'b0}, "add_cin");
      run_op(1, 16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, "sub_borrow");
      run_op(1, 16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, "sub_ovf");

      // Result holds while idle
      repeat (3) @(posedge clk);
      #1;
      chk("hold_sum", 32'(obs(1).sum), 32'h7FFF);
      chk("hold_ovf", 32'(obs(1).ovf), 32'd1);

      // start pulsed during busy with other operands is ignored
      sb.push_back('{16'h1234, 1'b0, 1'b0});
      set_in(1, 1'b1, 1'b0, 16'h1000, 16'h0234, 1'b0);
      @(posedge clk); #1;
      set_in(1, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      set_in(1, 1'b1, 1'b1, 16'hFFFF, 16'h5555, 1'b1);
      @(posedge clk); #1;
      set_in(1, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_done(1, lat);
      chk("ign_latency", 32'(lat + 2), 32'd4);
      pop_check(1, "ign");

      // start held through DONE: second operation starts with no idle cycle
      sb.push_back('{16'h0003, 1'b0, 1'b0});
      sb.push_back('{16'h0100, 1'b0, 1'b0});
      set_in(1, 1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0);
      @(posedge clk); #1;
      set_in(1, 1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0);
      wait_done(1, lat);
      chk("b2b_latency_a", 32'(lat), 32'd4);
      chk("b2b_busy_in_done", 32'(obs(1).busy), 32'd0);
      pop_check(1, "b2b_a");
      @(posedge clk); #1;
      chk("b2b_busy_next", 32'(obs(1).busy), 32'd1);
      chk("b2b_done_next", 32'(obs(1).done), 32'd0);
      set_in(1, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_done(1, lat);
      chk("b2b_latency_b", 32'(lat), 32'd4);
      pop_check(1, "b2b_b");

      // Reset in the 2nd RUN cycle aborts the operation
      set_in(1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      set_in(1, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      o = obs(1);
      chk("mid_rst_busy", 32'(o.busy), 32'd0);
      chk("mid_rst_sum",  32'(o.sum),  32'd0);
      chk("mid_rst_done", 32'(o.done), 32'd0);
      chk("mid_rst_cout", 32'(o.cout), 32'd0);
      #3;
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (obs(1).done) done_seen++;
      end
      chk("mid_rst_no_done", 32'(done_seen), 32'd0);
      run_op(1, 16'hABCD, 16'h1234, 1'b0, 1'b0, '{16'hBE01, 1'b0, 1'b0}, "post_rst");

      // Random sweep across CHUNK = 1, 4, 16
      for (int idx = 0; idx < 3; idx++) begin
         for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(idx, ra, rb, rs, rc, model(ra, rb, rs, rc), "sweep");
         end
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
